// File: rtl/evm_pkg.sv
// Purpose : shared constants and types for the voting-machine vote recorder.
// Latency : n/a (declarations only).
// Backpressure: n/a; contains no ports or logic.
package evm_pkg;

  localparam int N_CANDIDATES = 4;
  localparam int N_VOTERS     = 8;
  localparam int CNT_W        = 3;

  localparam int CAND_W  = $clog2(N_CANDIDATES);
  localparam int VOTER_W = $clog2(N_VOTERS);

  typedef logic [CAND_W-1:0]  cand_id_t;
  typedef logic [VOTER_W-1:0] voter_id_t;
  typedef logic [CNT_W-1:0]   tally_t;

  // Largest representable tally; increments stop here.
  localparam tally_t TALLY_MAX = '1;

endpackage

// File: rtl/vote_max_finder.sv
// Purpose : picks the candidate with the largest tally, lowest index wins ties.
// Latency : purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports   : i_counts   - per-candidate tallies
//           o_winner   - index of the leading candidate
//           o_max      - tally of that candidate
module vote_max_finder
  import evm_pkg::*;
(
  input  tally_t   i_counts [N_CANDIDATES],
  output cand_id_t o_winner,
  output tally_t   o_max
);

  cand_id_t w_winner;
  tally_t   w_max;

  // Scan upward and only replace on strictly greater, so the earliest
  // (lowest-index) candidate holds the lead on a tie.
  always_comb begin
    w_winner = '0;
    w_max    = i_counts[0];
    for (int i = 1; i < N_CANDIDATES; i++) begin
      if (i_counts[i] > w_max) begin
        w_max    = i_counts[i];
        w_winner = cand_id_t'(i);
      end
    end
  end

  assign o_winner = w_winner;
  assign o_max    = w_max;

endmodule

// File: rtl/memory_control_unit.sv
// Purpose : records one vote per voter ID into per-candidate tallies, reports leader.
// Latency : tally updates on the edge sampling the strobe rise; outputs one edge later.
// Backpressure: none; repeat voters are silently ignored, tallies saturate.
// Ports   : clk, rst (sync, active-high)
//           candidate_number, voter_number - ballot contents, sampled on strobe rise
//           vote_signal      - vote strobe, rising edge casts one ballot
//           winner_candidate - registered index of the leading candidate
//           out_vote         - registered tally of winner_candidate
module memory_control_unit
  import evm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  cand_id_t  candidate_number,
  input  voter_id_t voter_number,
  input  logic      vote_signal,
  output cand_id_t  winner_candidate,
  output tally_t    out_vote
);

  logic [N_VOTERS-1:0] r_voted;
  tally_t              r_count [N_CANDIDATES];
  logic                r_vote_signal_d;
  cand_id_t            r_winner;
  tally_t              r_out_vote;

  logic     w_vote_pulse;
  logic     w_accept;
  cand_id_t w_winner;
  tally_t   w_max;

  // A held strobe produces a single pulse, so it casts exactly one ballot.
  assign w_vote_pulse = vote_signal & ~r_vote_signal_d;
  assign w_accept     = w_vote_pulse & ~r_voted[voter_number];

  vote_max_finder u_max (
    .i_counts (r_count),
    .o_winner (w_winner),
    .o_max    (w_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_voted         <= '0;
      r_vote_signal_d <= 1'b0;
      r_winner        <= '0;
      r_out_vote      <= '0;
      for (int i = 0; i < N_CANDIDATES; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      r_vote_signal_d <= vote_signal;
      if (w_accept) begin
        // The voter is marked even when the tally is already saturated.
        r_voted[voter_number] <= 1'b1;
        if (r_count[candidate_number] != TALLY_MAX) begin
          r_count[candidate_number] <= r_count[candidate_number] + tally_t'(1);
        end
      end
      r_winner   <= w_winner;
      r_out_vote <= w_max;
    end
  end

  assign winner_candidate = r_winner;
  assign out_vote         = r_out_vote;

endmodule

// File: tb/tb_memory_control_unit.sv
// Purpose : directed self-checking bench for memory_control_unit.
// Latency : checks outputs two or more edges after each strobe rise.
// Backpressure: n/a; the bench drives every input directly.
module tb_memory_control_unit;

  logic       clk;
  logic       rst;
  logic [1:0] candidate_number;
  logic [2:0] voter_number;
  logic       vote_signal;
  logic [1:0] winner_candidate;
  logic [2:0] out_vote;

  int n_checks = 0;
  int n_fail   = 0;

  memory_control_unit dut (
    .clk              (clk),
    .rst              (rst),
    .candidate_number (candidate_number),
    .voter_number     (voter_number),
    .vote_signal      (vote_signal),
    .winner_candidate (winner_candidate),
    .out_vote         (out_vote)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] voter;
    logic [1:0] cand;
    int         hold;
    logic [1:0] exp_winner;
    logic [2:0] exp_vote;
    string      name;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [1:0] exp_w, input logic [2:0] exp_v);
    n_checks++;
    if (winner_candidate !== exp_w) begin
      n_fail++;
      $display("FAIL %s winner_candidate: got %0d expected %0d", name, winner_candidate, exp_w);
    end
    n_checks++;
    if (out_vote !== exp_v) begin
      n_fail++;
      $display("FAIL %s out_vote: got %0d expected %0d", name, out_vote, exp_v);
    end
  endtask

  // Raise the strobe for 'hold' cycles; after the first sampling edge the
  // ballot fields are scrambled since they should only matter on the pulse.
  task automatic cast(input logic [2:0] voter, input logic [1:0] cand, input int hold);
    @(negedge clk);
    voter_number     = voter;
    candidate_number = cand;
    vote_signal      = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      voter_number     = 3'($urandom);
      candidate_number = 2'($urandom);
    end
    vote_signal = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Counts after each entry shown as {c0,c1,c2,c3}.
    vecs[0] = '{3'd0, 2'd0,  2, 2'd0, 3'd1, "v0_c0 {1,0,0,0}"};
    vecs[1] = '{3'd1, 2'd1,  2, 2'd0, 3'd1, "v1_c1 tie {1,1,0,0}"};
    vecs[2] = '{3'd2, 2'd1,  2, 2'd1, 3'd2, "v2_c1 {1,2,0,0}"};
    vecs[3] = '{3'd0, 2'd1,  2, 2'd1, 3'd2, "v0 repeat rejected"};
    vecs[4] = '{3'd4, 2'd2,  1, 2'd1, 3'd2, "v4_c2 {1,2,1,0}"};
    vecs[5] = '{3'd3, 2'd1,  2, 2'd1, 3'd3, "v3_c1 {1,3,1,0}"};
    vecs[6] = '{3'd5, 2'd3, 10, 2'd1, 3'd3, "v5_c3 held {1,3,1,1}"};
    vecs[7] = '{3'd6, 2'd3,  2, 2'd1, 3'd3, "v6_c3 {1,3,1,2}"};
    // If the held strobe double-counted, c3 would be 4 and lead here.
    vecs[8] = '{3'd7, 2'd3,  2, 2'd1, 3'd3, "v7_c3 tie {1,3,1,3}"};

    rst              = 1'b1;
    vote_signal      = 1'b0;
    voter_number     = '0;
    candidate_number = '0;
    repeat (3) @(negedge clk);
    chk("reset state", 2'd0, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", 2'd0, 3'd0);

    for (int i = 0; i < 9; i++) begin
      cast(vecs[i].voter, vecs[i].cand, vecs[i].hold);
      chk(vecs[i].name, vecs[i].exp_winner, vecs[i].exp_vote);
    end

    // Reset asserted in the same cycle the strobe rises: reset wins, and the
    // still-high strobe casts voter0's ballot on the first non-reset edge.
    @(negedge clk);
    rst              = 1'b1;
    vote_signal      = 1'b1;
    voter_number     = 3'd0;
    candidate_number = 2'd0;
    @(negedge clk);
    chk("mid-election reset", 2'd0, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset pulse latency", 2'd0, 3'd0);
    @(negedge clk);
    chk("voter0 eligible again", 2'd0, 3'd1);
    vote_signal = 1'b0;
    @(negedge clk);
    chk("no vote while low", 2'd0, 3'd1);

    // Saturation: all eight voters pick candidate 2.
    do_reset();
    @(negedge clk);
    chk("second reset", 2'd0, 3'd0);
    for (int v = 0; v < 8; v++) begin
      cast(3'(v), 2'd2, 1);
      chk($sformatf("saturate v%0d", v), 2'd2, (v >= 6) ? 3'd7 : 3'(v + 1));
    end
    cast(3'd7, 2'd0, 2);
    chk("ninth attempt v7", 2'd2, 3'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
